// File: rtl/sample_decimator_pkg.sv
// Shared constants for the sample decimator: sample width, display limits and gain width.
package sample_decimator_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int GAIN_W       = 2;

    localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MIN = 16'h8000;

endpackage

// File: rtl/sample_decimator_sat_shift.sv
// Combinational signed left shift by 0..3 followed by a clamp to the OUT_W signed range.
module sat_shift
    import sample_decimator_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
)
(
    input  logic signed [IN_W-1:0]  din,
    input  logic        [GAIN_W-1:0] shift,
    output logic signed [OUT_W-1:0] dout
);

    // Wide enough that the largest shift cannot lose bits before the clamp decides.
    localparam int WIDE_W = IN_W + (1 << GAIN_W) - 1;
    localparam logic signed [WIDE_W-1:0] POS_LIM = WIDE_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [WIDE_W-1:0] NEG_LIM = WIDE_W'(-(64'sd1 <<< (OUT_W - 1)));

    logic signed [WIDE_W-1:0] wide;

    always_comb begin
        wide = WIDE_W'(din) <<< shift;
        if (wide > POS_LIM) begin
            dout = POS_LIM[OUT_W-1:0];
        end else if (wide < NEG_LIM) begin
            dout = NEG_LIM[OUT_W-1:0];
        end else begin
            dout = wide[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/sample_decimator.sv
// Box-car decimator: averages blocks of 2**DECIM_LOG2 samples, applies a saturating
// power-of-two gain and emits one new_sample pulse per block; freeze holds the trace.
module sample_decimator
    import sample_decimator_pkg::*;
#(
    parameter int DECIM_LOG2 = 2,
    parameter int SAMPLE_W   = SAMPLE_W_DEF
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       freeze,
    input  logic        [GAIN_W-1:0]   gain_shift,
    output logic                       new_sample,
    output logic signed [SAMPLE_W-1:0] sample_out
);

    localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    total;
    logic signed [ACC_W-1:0]    avg;
    logic signed [SAMPLE_W-1:0] res;
    logic                       last;

    assign total = acc + ACC_W'(sample_in);
    assign avg   = total >>> DECIM_LOG2;

    // The block counter only exists when blocks are longer than one sample.
    generate
        if (DECIM_LOG2 > 0) begin : g_cnt
            logic [DECIM_LOG2-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt <= '0;
                end else if (freeze) begin
                    cnt <= '0;
                end else if (sample_valid) begin
                    cnt <= cnt + DECIM_LOG2'(1);
                end
            end

            assign last = &cnt;
        end else begin : g_no_cnt
            assign last = 1'b1;
        end
    endgenerate

    sat_shift #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_W)
    ) u_sat_shift (
        .din   (avg),
        .shift (gain_shift),
        .dout  (res)
    );

    // Freeze discards any partial block; the last sample of a block launches the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            new_sample <= 1'b0;
            sample_out <= '0;
        end else begin
            new_sample <= 1'b0;
            if (freeze) begin
                acc <= '0;
            end else if (sample_valid) begin
                if (last) begin
                    acc        <= '0;
                    sample_out <= res;
                    new_sample <= 1'b1;
                end else begin
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_decimator.sv
// Self-checking bench for sample_decimator: directed scenarios plus a randomized run
// against a block-averaging reference model built from queues and integer arithmetic.
module tb_sample_decimator;

    logic clk;
    logic reset;

    logic               sv2, fr2;
    logic signed [15:0] si2;
    logic        [1:0]  gs2;
    logic               ns2;
    logic signed [15:0] so2;

    logic               sv0, fr0;
    logic signed [15:0] si0;
    logic        [1:0]  gs0;
    logic               ns0;
    logic signed [15:0] so0;

    int n_checks = 0;
    int n_pass   = 0;

    sample_decimator #(.DECIM_LOG2(2), .SAMPLE_W(16)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (si2),
        .sample_valid (sv2),
        .freeze       (fr2),
        .gain_shift   (gs2),
        .new_sample   (ns2),
        .sample_out   (so2)
    );

    sample_decimator #(.DECIM_LOG2(0), .SAMPLE_W(16)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (si0),
        .sample_valid (sv0),
        .freeze       (fr0),
        .gain_shift   (gs0),
        .new_sample   (ns0),
        .sample_out   (so0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor-average of a block, scaled by 2**g, clamped to 16-bit signed.
    function automatic logic [15:0] model(input longint sum, input int n_log2, input int g);
        longint div, avg, res;
        logic [63:0] bits;
        div = longint'(1) << n_log2;
        avg = sum / div;
        if ((sum % div != 0) && (sum < 0)) avg = avg - 1;
        res = avg * (longint'(1) << g);
        if (res > 32767)  res = 32767;
        if (res < -32768) res = -32768;
        bits = res;
        return bits[15:0];
    endfunction

    task automatic drive2(input logic v, input logic signed [15:0] d, input logic f, input logic [1:0] g);
        @(negedge clk);
        sv2 = v; si2 = d; fr2 = f; gs2 = g;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic signed [15:0] d, input logic [1:0] g);
        @(negedge clk);
        sv0 = v; si0 = d; fr0 = 1'b0; gs0 = g;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ns2 !== 1'b0) $display("FAIL reset_ns2: got %b want 0", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'h0) $display("FAIL reset_so2: got %h want 0000", so2); else n_pass++;
        n_checks++; if (ns0 !== 1'b0) $display("FAIL reset_ns0: got %b want 0", ns0); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (so0 !== 16'h0) $display("FAIL post_reset_so0: got %h want 0000", so0); else n_pass++;
        n_checks++; if (ns2 !== 1'b0) $display("FAIL post_reset_ns2: got %b want 0", ns2); else n_pass++;
    endtask

    task automatic test_average;
        logic signed [15:0] vals [4];
        vals = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, vals[i], 1'b0, 2'd0);
            if (i < 3) begin
                n_checks++; if (ns2 !== 1'b0) $display("FAIL avg_early_pulse: got %b want 0 (i=%0d)", ns2, i); else n_pass++;
            end
        end
        n_checks++; if (ns2 !== 1'b1) $display("FAIL avg_pulse: got %b want 1", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'sd250) $display("FAIL avg_value: got %0d want 250", so2); else n_pass++;
        drive2(1'b0, 16'sd0, 1'b0, 2'd0);
        n_checks++; if (ns2 !== 1'b0) $display("FAIL avg_one_cycle: got %b want 0", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'sd250) $display("FAIL avg_hold: got %0d want 250", so2); else n_pass++;
    endtask

    task automatic test_floor;
        logic signed [15:0] vals [4];
        vals = '{-16'sd1, -16'sd2, -16'sd2, -16'sd2};
        for (int i = 0; i < 4; i++) drive2(1'b1, vals[i], 1'b0, 2'd0);
        n_checks++; if (ns2 !== 1'b1) $display("FAIL floor_pulse: got %b want 1", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'hFFFE) $display("FAIL floor_value: got %h want fffe", so2); else n_pass++;
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 4; i++) drive2(1'b1, 16'sh2000, 1'b0, 2'd3);
        n_checks++; if (so2 !== 16'h7FFF) $display("FAIL sat_pos: got %h want 7fff", so2); else n_pass++;
        for (int i = 0; i < 4; i++) drive2(1'b1, 16'shE000, 1'b0, 2'd2);
        n_checks++; if (so2 !== 16'h8000) $display("FAIL sat_neg: got %h want 8000", so2); else n_pass++;
        // Gain changes before the last sample must not matter.
        for (int i = 0; i < 4; i++) drive2(1'b1, 16'sd10, 1'b0, (i < 3) ? 2'd3 : 2'd0);
        n_checks++; if (so2 !== 16'sd10) $display("FAIL gain_last_only: got %0d want 10", so2); else n_pass++;
    endtask

    task automatic test_freeze;
        logic [15:0] held;
        held = so2;
        drive2(1'b1, 16'sd1000, 1'b0, 2'd0);
        drive2(1'b1, 16'sd1000, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive2(1'b1, 16'sd1000, 1'b1, 2'd0);
            n_checks++; if (ns2 !== 1'b0) $display("FAIL freeze_no_pulse: got %b want 0 (i=%0d)", ns2, i); else n_pass++;
        end
        n_checks++; if (so2 !== held) $display("FAIL freeze_hold: got %h want %h", so2, held); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, 16'sd8, 1'b0, 2'd0);
            if (i < 3) begin
                n_checks++; if (ns2 !== 1'b0) $display("FAIL freeze_restart_early: got %b want 0 (i=%0d)", ns2, i); else n_pass++;
            end
        end
        n_checks++; if (ns2 !== 1'b1) $display("FAIL freeze_restart_pulse: got %b want 1", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'sd8) $display("FAIL freeze_restart_value: got %0d want 8", so2); else n_pass++;
    endtask

    task automatic test_async_reset;
        logic signed [15:0] vals [4];
        for (int i = 0; i < 3; i++) drive2(1'b1, 16'sd500, 1'b0, 2'd0);
        drive2(1'b0, 16'sd0, 1'b0, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (ns2 !== 1'b0) $display("FAIL async_reset_ns: got %b want 0", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'h0) $display("FAIL async_reset_so: got %h want 0000", so2); else n_pass++;
        #1;
        reset = 1'b0;
        vals = '{16'sd40, 16'sd40, 16'sd40, 16'sd44};
        for (int i = 0; i < 4; i++) drive2(1'b1, vals[i], 1'b0, 2'd0);
        n_checks++; if (ns2 !== 1'b1) $display("FAIL async_after_pulse: got %b want 1", ns2); else n_pass++;
        n_checks++; if (so2 !== 16'sd41) $display("FAIL async_after_value: got %0d want 41", so2); else n_pass++;
        drive2(1'b0, 16'sd0, 1'b0, 2'd0);
    endtask

    task automatic test_passthrough;
        drive0(1'b1, 16'sd5, 2'd1);
        n_checks++; if (ns0 !== 1'b1) $display("FAIL pass_pulse1: got %b want 1", ns0); else n_pass++;
        n_checks++; if (so0 !== 16'sd10) $display("FAIL pass_value1: got %0d want 10", so0); else n_pass++;
        drive0(1'b1, -16'sd20000, 2'd1);
        n_checks++; if (ns0 !== 1'b1) $display("FAIL pass_pulse2: got %b want 1", ns0); else n_pass++;
        n_checks++; if (so0 !== 16'h8000) $display("FAIL pass_value2: got %h want 8000", so0); else n_pass++;
        drive0(1'b0, 16'sd0, 2'd1);
        n_checks++; if (ns0 !== 1'b0) $display("FAIL pass_idle: got %b want 0", ns0); else n_pass++;
    endtask

    task automatic test_random;
        int          blk [$];
        logic [15:0] exp_out;
        logic        exp_pulse;
        logic        v, f;
        logic [1:0]  g;
        logic signed [15:0] d;
        longint      sum;

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_out = 16'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 19) == 0);
            g = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            drive2(v, d, f, g);
            exp_pulse = 1'b0;
            if (f) begin
                blk.delete();
            end else if (v) begin
                blk.push_back(int'(d));
                if (blk.size() == 4) begin
                    sum = 0;
                    foreach (blk[k]) sum += blk[k];
                    exp_out   = model(sum, 2, int'(g));
                    exp_pulse = 1'b1;
                    blk.delete();
                end
            end
            n_checks++; if (ns2 !== exp_pulse) $display("FAIL rand_pulse: cycle %0d got %b want %b", cyc, ns2, exp_pulse); else n_pass++;
            n_checks++; if (so2 !== exp_out) $display("FAIL rand_value: cycle %0d got %h want %h", cyc, so2, exp_out); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        sv2 = 1'b0; si2 = '0; fr2 = 1'b0; gs2 = '0;
        sv0 = 1'b0; si0 = '0; fr0 = 1'b0; gs0 = '0;
        test_reset();
        test_average();
        test_floor();
        test_saturate();
        test_freeze();
        test_async_reset();
        test_passthrough();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
